// File: rtl/rf_access_ctrl.sv
// ============================================================================
// rf_access_ctrl : single-command initiator for a 2R/1W register file.
//   Optional build macro: RF_ZERO_REG_EN (index 0 reads as zero, never written)
//   Revision: 1.0
// ============================================================================
`default_nettype none

module rf_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic [DATA_WIDTH-1:0] rsp_data2,
  output logic [ADDR_WIDTH-1:0] rf_addr1,
  output logic [ADDR_WIDTH-1:0] rf_addr2,
  output logic [ADDR_WIDTH-1:0] rf_addr_write,
  output logic [DATA_WIDTH-1:0] rf_datain,
  output logic                  rf_write_enable,
  output logic                  rf_mode,
  input  logic [DATA_WIDTH-1:0] rf_dataout1,
  input  logic [DATA_WIDTH-1:0] rf_dataout2
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] res1_q, res2_q;
  logic                  wr_strobe;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rdata1, rdata2;
  logic [DATA_WIDTH:0]   sum;

`ifdef RF_ZERO_REG_EN
  assign rdata1 = (rs1_q == '0) ? '0 : rf_dataout1;
  assign rdata2 = (rs2_q == '0) ? '0 : rf_dataout2;
`else
  assign rdata1 = rf_dataout1;
  assign rdata2 = rf_dataout2;
`endif

  assign sum    = {1'b0, rdata1} + {1'b0, rdata2};
  assign accept = cmd_valid && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= cmd_rd;
        if (cmd_op == OP_WRITE) begin
          res1_q <= cmd_imm;
          res2_q <= '0;
        end
      end
      if (state_q == S_CAP) begin
        case (op_q)
          OP_READ: begin
            res1_q <= rdata1;
            res2_q <= rdata2;
          end
          OP_ADD: begin
            res1_q <= sum[DATA_WIDTH-1:0];
            res2_q <= {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH]};
          end
          default: begin
            res1_q <= rdata1;
            res2_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_strobe = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_op == OP_WRITE) ? S_WR : S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = (op_q == OP_READ) ? S_RSP : S_WR;
      S_WR: begin
        wr_strobe = 1'b1;
        state_d   = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write data is always the primary result word: imm, sum or the copied value.
`ifdef RF_ZERO_REG_EN
  assign rf_write_enable = wr_strobe && !rst && (rd_q != '0);
`else
  assign rf_write_enable = wr_strobe && !rst;
`endif
  assign rf_datain     = res1_q;
  assign rf_addr1      = rs1_q;
  assign rf_addr2      = rs2_q;
  assign rf_addr_write = rd_q;
  assign rf_mode       = 1'b1;
  assign rsp_data1     = res1_q;
  assign rsp_data2     = res2_q;

endmodule

`default_nettype wire
